// File: rtl/detector_borda_multi.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter, mode-qualified edge pulse,
// sticky flag (write-1-to-clear) and saturating event counter.
module detector_borda_multi #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       entrada,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       clear,
    output logic [WIDTH-1:0]       detector,
    output logic [WIDTH-1:0]       sticky,
    output logic [WIDTH*CNT_W-1:0] contagem,
    output logic                   qualquer
);

    localparam int             FW   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [FW-1:0]  FMAX = FW'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= entrada;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    genvar g;
    for (g = 0; g < WIDTH; g++) begin : g_ch
        logic [FW-1:0]    fcnt;
        logic             filt;
        logic             upd;
        logic             qual;
        logic             det_q;
        logic             stk_q;
        logic [CNT_W-1:0] cnt;

        assign upd  = (s[g] != filt) && (fcnt == FMAX);
        // The new level of s is the direction of the accepted transition.
        assign qual = upd && (s[g] ? mode[0] : mode[1]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                filt <= 1'b0;
                fcnt <= '0;
            end else if (s[g] == filt) begin
                fcnt <= '0;
            end else if (fcnt == FMAX) begin
                filt <= s[g];
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end

        // A qualified event outranks a simultaneous clear so that no event is lost.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                det_q <= 1'b0;
                stk_q <= 1'b0;
                cnt   <= '0;
            end else begin
                det_q <= qual;
                if (qual) begin
                    stk_q <= 1'b1;
                    if (clear[g])          cnt <= CNT_W'(1);
                    else if (cnt != CMAX)  cnt <= cnt + CNT_W'(1);
                end else if (clear[g]) begin
                    stk_q <= 1'b0;
                    cnt   <= '0;
                end
            end
        end

        assign detector[g]                 = det_q;
        assign sticky[g]                   = stk_q;
        assign contagem[g*CNT_W +: CNT_W]  = cnt;
    end

    assign qualquer = |detector;

endmodule

// File: tb/tb_detector_borda_multi.sv
// Directed bench for detector_borda_multi: default instance plus a CNT_W=2 instance for saturation.
module tb_detector_borda_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  entrada;
    logic [1:0]  mode;
    logic [7:0]  clear;
    logic [7:0]  detector, sticky;
    logic [63:0] contagem;
    logic        qualquer;
    logic [7:0]  detector_s, sticky_s;
    logic [15:0] contagem_s;
    logic        qualquer_s;

    int tests = 0;
    int fails = 0;

    detector_borda_multi dut (
        .clk(clk), .rst(rst), .entrada(entrada), .mode(mode), .clear(clear),
        .detector(detector), .sticky(sticky), .contagem(contagem), .qualquer(qualquer)
    );

    detector_borda_multi #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .entrada(entrada), .mode(mode), .clear(clear),
        .detector(detector_s), .sticky(sticky_s), .contagem(contagem_s), .qualquer(qualquer_s)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_clear(input logic [7:0] m);
        clear = m;
        step(1);
        clear = '0;
    endtask

    logic [7:0] exp_cnt [8];

    initial begin
        rst = 1'b1; entrada = '0; mode = 2'b01; clear = '0;
        step(2);
        check("reset_detector", detector, 8'h00);
        check("reset_sticky",   sticky,   8'h00);
        check("reset_contagem", contagem, 64'h0);
        check("reset_qualquer", qualquer, 1'b0);

        // Rising edge on ch0: release reset and raise input before edge 1
        rst = 1'b0; entrada[0] = 1'b1;
        step(5);
        check("rise_edge5_det", detector, 8'h00);
        step(1);
        check("rise_edge6_det", detector, 8'h01);
        check("rise_edge6_any", qualquer, 1'b1);
        check("rise_sticky",    sticky,   8'h01);
        check("rise_cnt0",      contagem[7:0], 8'd1);
        check("rise_cnt_rest",  contagem[63:8], 56'h0);
        step(1);
        check("rise_edge7_det", detector, 8'h00);
        check("rise_edge7_any", qualquer, 1'b0);

        // Glitch filter on ch1
        mode = 2'b11;
        entrada[1] = 1'b1; step(3); entrada[1] = 1'b0;
        step(10);
        check("glitch3_sticky", sticky[1], 1'b0);
        check("glitch3_cnt",    contagem[15:8], 8'd0);
        entrada[1] = 1'b1; step(4); entrada[1] = 1'b0;
        step(2);
        check("pulse4_rise_det", detector, 8'h02);
        step(3);
        check("pulse4_mid_det",  detector, 8'h00);
        step(1);
        check("pulse4_fall_det", detector, 8'h02);
        step(1);
        check("pulse4_cnt",      contagem[15:8], 8'd2);

        // Modes on ch2: rise then fall, counter cleared before each run
        mode = 2'b00; pulse_clear(8'h04);
        entrada[2] = 1'b1; step(8); entrada[2] = 1'b0; step(10);
        check("mode00_cnt",    contagem[23:16], 8'd0);
        check("mode00_sticky", sticky[2], 1'b0);
        mode = 2'b01; pulse_clear(8'h04);
        entrada[2] = 1'b1; step(8);
        check("mode01_rise_cnt", contagem[23:16], 8'd1);
        entrada[2] = 1'b0; step(10);
        check("mode01_cnt",    contagem[23:16], 8'd1);
        mode = 2'b10; pulse_clear(8'h04);
        entrada[2] = 1'b1; step(8);
        check("mode10_rise_cnt", contagem[23:16], 8'd0);
        entrada[2] = 1'b0; step(10);
        check("mode10_cnt",    contagem[23:16], 8'd1);
        mode = 2'b11; pulse_clear(8'h04);
        entrada[2] = 1'b1; step(8); entrada[2] = 1'b0; step(10);
        check("mode11_cnt",    contagem[23:16], 8'd2);

        // Clear coinciding with a qualified event on ch3, then clear alone
        entrada[3] = 1'b1; step(8);
        check("clr_pre_cnt", contagem[31:24], 8'd1);
        entrada[3] = 1'b0; step(5);
        clear = 8'h08; step(1); clear = '0;
        check("clr_evt_det",    detector[3], 1'b1);
        check("clr_evt_sticky", sticky[3], 1'b1);
        check("clr_evt_cnt",    contagem[31:24], 8'd1);
        step(2);
        pulse_clear(8'h08);
        check("clr_only_sticky", sticky[3], 1'b0);
        check("clr_only_cnt",    contagem[31:24], 8'd0);

        // Saturation on ch4: five events
        for (int k = 0; k < 5; k++) begin
            entrada[4] = ~entrada[4];
            step(8);
        end
        check("sat_cnt_w2", contagem_s[9:8], 2'd3);
        check("sat_cnt_w8", contagem[39:32], 8'd5);

        // Simultaneous edges on all channels
        exp_cnt = '{8'd2, 8'd3, 8'd3, 8'd1, 8'd6, 8'd1, 8'd1, 8'd1};
        entrada = ~entrada;
        step(5);
        check("multi_pre_det", detector, 8'h00);
        step(1);
        check("multi_det", detector, 8'hFF);
        check("multi_any", qualquer, 1'b1);
        step(1);
        check("multi_post_det", detector, 8'h00);
        for (int i = 0; i < 8; i++) check($sformatf("multi_cnt%0d", i), contagem[i*8 +: 8], exp_cnt[i]);
        check("multi_sat_hold", contagem_s[9:8], 2'd3);

        // Asynchronous reset while filters are mid-count
        entrada = '0;
        step(4);
        #3 rst = 1'b1;
        #1;
        check("arst_detector", detector, 8'h00);
        check("arst_sticky",   sticky,   8'h00);
        check("arst_contagem", contagem, 64'h0);
        check("arst_cnt_sat",  contagem_s, 16'h0);
        check("arst_qualquer", qualquer, 1'b0);
        step(2);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            check($sformatf("post_arst_any%0d", k), qualquer, 1'b0);
        end
        check("post_arst_sticky", sticky, 8'h00);
        check("post_arst_cnt",    contagem, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
